tick_prescaler: RTL and testbench
=================================

TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 The block SHALL have parameter WIDTH, default `WW, data and register width; MSB = WIDTH-1.
REQ-002 The block SHALL have port sysclk  input  1  system clock, all state on its rising edge.
REQ-003 The block SHALL have port sysreset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port data_in  input  WIDTH  shared write data for both registers.
REQ-005 The block SHALL have port ctrl_load  input  1  writes data_in into the control register on this edge.
REQ-006 The block SHALL have port ctrl_data_out  output  WIDTH  control/status read-back.
REQ-007 The block SHALL have port div_load  input  1  writes data_in into the divisor register on this edge.
REQ-008 The block SHALL have port div_data_out  output  WIDTH  divisor register read-back, exactly as written.
REQ-009 The block SHALL have port ext_event  input  1  asynchronous external event pin.
REQ-010 The block SHALL have port tick  output  1  registered tick pulse, intended for a downstream counter's counter_tick.

Function
REQ-011 The control register SHALL hold: bit0 enable; bits2:1 source (00 sysclk, 01 ext rising, 10 ext falling, 11 ext both edges); all other written bits ignored.
REQ-012 ctrl_data_out SHALL read bit0 enable, bits2:1 source, bit3 synchronized ext level (read-only), and all upper bits 0.
REQ-013 ext_event SHALL pass through a 2-flop synchronizer followed by a previous-value flop; edges SHALL be detected only on synchronized values.
REQ-014 A qualified event SHALL occur in a cycle when enable=1 and either source=00, or the selected synchronized edge is present.
REQ-015 The effective divisor SHALL be D = max(divisor, 1); the prescale count SHALL run 0..D, incrementing by 1 per qualified event.
REQ-016 A qualified event with count==D SHALL set count to 0 and cause tick=1 on the following cycle; period = D+1 qualified events.
REQ-017 tick SHALL be high for exactly one sysclk cycle per period and low at least one cycle between pulses; minimum tick period is 2 cycles.
REQ-018 Latency: with source=00, a qualified event at edge k with count==D SHALL give tick=1 from edge k+1 to edge k+2.
REQ-019 Latency: with source!=00, an ext_event change first sampled at edge k SHALL give tick=1 after edge k+3 if it completes a period.
REQ-020 div_load SHALL clear count to 0 and force tick=0 on the next cycle; any qualified event in the same cycle SHALL be dropped.
REQ-021 ctrl_load SHALL clear count to 0 and force tick=0 next cycle; the new enable/source take effect for qualification from the following cycle.
REQ-022 With enable=0, count SHALL hold at 0, tick SHALL stay 0, and synchronizer flops SHALL keep tracking ext_event.
REQ-023 When div_load and ctrl_load are simultaneous, both registers SHALL load and count SHALL clear.
REQ-024 The divisor register SHALL accept any WIDTH-bit value; divisor of all ones SHALL count to 2^WIDTH-1 without overflow or wrap error.

Reset
REQ-025 sysreset SHALL asynchronously clear the control register, divisor register, count, tick, and all synchronizer/edge flops to 0.
REQ-026 After reset, tick=0, ctrl_data_out=0 (bit3 follows synchronized ext_event after 2 edges), and div_data_out=0.
REQ-027 A reset asserted mid-period SHALL abort the period with no tick emitted; counting restarts only after enable is rewritten.

Verification
REQ-028 Scenario: div=3, ctrl=0x1 (source sysclk) -> tick is 1 cycle high every 4 cycles, first pulse 4 cycles after the ctrl write.
REQ-029 Scenario: div=0, then div=1, with source sysclk -> tick alternates 1,0,1,0 in both cases.
REQ-030 Scenario: ctrl=0x7 (both edges), div=1, 4 ext_event toggles spaced 5 cycles -> 2 ticks, each 3 edges after the sample of the completing toggle.
REQ-031 Scenario: ctrl=0x5 (falling), div=2, 3 rising and 3 falling ext edges -> exactly 1 tick, on the 3rd falling edge.
REQ-032 Scenario: source sysclk, div=5, div_load of 5 issued at count==5 in the cycle of a qualified event -> no tick; the next tick arrives 6 events later.
REQ-033 Scenario: sysreset pulsed mid-period at count==2 -> tick=0, ctrl_data_out[2:0]=0, div_data_out=0 immediately, and no ticks until re-enabled.

Source files
------------

// File: rtl/tick_prescaler.sv
// Tick prescaler: divides sysclk or a synchronized external event by a
// programmable divisor (D+1 events per period) and emits a one-cycle tick
// for a downstream counter. Control and divisor registers share data_in.

`ifndef WW
`define WW 8
`endif

module tick_prescaler #(
  parameter int WIDTH = `WW
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ctrl_load,
  output logic [WIDTH-1:0] ctrl_data_out,
  input  logic             div_load,
  output logic [WIDTH-1:0] div_data_out,
  input  logic             ext_event,
  output logic             tick
);

  localparam logic [1:0] SRC_SYSCLK = 2'b00;
  localparam logic [1:0] SRC_RISE   = 2'b01;
  localparam logic [1:0] SRC_FALL   = 2'b10;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // ctrl_q[0] = enable, ctrl_q[2:1] = event source
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // ext_event synchronizer, previous-value flop and registered edge flags
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  logic [WIDTH-1:0] eff_div;
  logic             src_hit;
  logic             qual;

  // Next-state logic: register writes, edge detection, qualification, counting
  always_comb begin
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    count_d = count_q;
    tick_d  = 1'b0;
    src_hit = 1'b0;

    // Edges are taken only between synchronized samples, then registered
    sync1_d = ext_event;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
    fall_d  = ~sync2_q & prev_q;

    // A zero divisor behaves like one so the tick never stays stuck high
    eff_div = (div_q == '0) ? ONE : div_q;

    case (ctrl_q[2:1])
      SRC_SYSCLK: src_hit = 1'b1;
      SRC_RISE:   src_hit = rise_q;
      SRC_FALL:   src_hit = fall_q;
      default:    src_hit = rise_q | fall_q;
    endcase
    qual = ctrl_q[0] & src_hit;

    if (ctrl_load) ctrl_d = data_in[2:0];
    if (div_load)  div_d  = data_in;

    // Any register write restarts the period and swallows this cycle's event
    if (ctrl_load || div_load) begin
      count_d = '0;
    end else if (!ctrl_q[0]) begin
      count_d = '0;
    end else if (qual) begin
      if (count_q == eff_div) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      ctrl_q  <= '0;
      div_q   <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Read-back: enable, source, synchronized ext level, upper bits zero
  always_comb begin
    ctrl_data_out      = '0;
    ctrl_data_out[2:0] = ctrl_q;
    ctrl_data_out[3]   = sync2_q;
  end

  assign div_data_out = div_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Bench for tick_prescaler: a cycle model predicts tick and read-back values,
// expected ticks are queued when each cycle is driven and popped after the edge.

module tb_tick_prescaler;

  localparam int WIDTH = 8;

  logic             sysclk = 1'b0;
  logic             sysreset;
  logic [WIDTH-1:0] data_in;
  logic             ctrl_load;
  logic [WIDTH-1:0] ctrl_data_out;
  logic             div_load;
  logic [WIDTH-1:0] div_data_out;
  logic             ext_event;
  logic             tick;

  always #5 sysclk = ~sysclk;

  tick_prescaler #(.WIDTH(WIDTH)) dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .data_in       (data_in),
    .ctrl_load     (ctrl_load),
    .ctrl_data_out (ctrl_data_out),
    .div_load      (div_load),
    .div_data_out  (div_data_out),
    .ext_event     (ext_event),
    .tick          (tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic exp_q[$];
  int   tick_steps[$];
  int   step_no;
  logic [31:0] tick_hist;

  // reference model state
  logic [2:0]       m_ctrl;
  logic [WIDTH-1:0] m_div, m_cnt;
  logic             m_s1, m_s2, m_prev, m_rq, m_fq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_div = '0; m_cnt = '0;
    m_s1 = 0; m_s2 = 0; m_prev = 0; m_rq = 0; m_fq = 0;
  endtask

  // One sysclk edge of the expected behaviour, using the inputs now applied
  task automatic model_step(output logic t);
    logic [WIDTH-1:0] d;
    logic ev;
    d = (m_div == 0) ? 8'd1 : m_div;
    case (m_ctrl[2:1])
      2'b00:   ev = 1'b1;
      2'b01:   ev = m_rq;
      2'b10:   ev = m_fq;
      default: ev = m_rq | m_fq;
    endcase
    ev = ev & m_ctrl[0];
    t  = 1'b0;
    if (ctrl_load || div_load) m_cnt = 0;
    else if (ev) begin
      if (m_cnt == d) begin m_cnt = 0; t = 1'b1; end
      else m_cnt = m_cnt + 1;
    end
    if (ctrl_load) m_ctrl = data_in[2:0];
    if (div_load)  m_div  = data_in;
    m_rq   = m_s2 & ~m_prev;
    m_fq   = ~m_s2 & m_prev;
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = ext_event;
  endtask

  task automatic step();
    logic t, e;
    model_step(t);
    exp_q.push_back(t);
    @(posedge sysclk);
    #1;
    step_no++;
    e = exp_q.pop_front();
    check_eq("tick", tick, e);
    check_eq("ctrl_rb", ctrl_data_out, {4'b0, m_s2, m_ctrl});
    check_eq("div_rb", div_data_out, m_div);
    tick_hist = {tick_hist[30:0], tick};
    if (tick) tick_steps.push_back(step_no);
  endtask

  task automatic clear_log();
    step_no = 0;
    tick_hist = '0;
    tick_steps.delete();
  endtask

  task automatic wr_ctrl(input logic [WIDTH-1:0] v);
    data_in = v; ctrl_load = 1'b1; step(); ctrl_load = 1'b0;
  endtask

  task automatic wr_div(input logic [WIDTH-1:0] v);
    data_in = v; div_load = 1'b1; step(); div_load = 1'b0;
  endtask

  function automatic int tick_at(input int idx);
    if (idx < tick_steps.size()) return tick_steps[idx];
    return -1;
  endfunction

  initial begin
    sysreset = 1'b1; data_in = '0; ctrl_load = 0; div_load = 0; ext_event = 0;
    model_reset();
    #1;
    check_eq("rst_tick", tick, 0);
    check_eq("rst_ctrl", ctrl_data_out, 0);
    check_eq("rst_div", div_data_out, 0);
    @(posedge sysclk); @(posedge sysclk); #1;
    sysreset = 1'b0;
    clear_log();
    repeat (3) step();
    check_eq("idle_ticks", tick_steps.size(), 0);

    // read-back: upper ctrl bits ignored, divisor exact
    wr_ctrl(8'hF8);
    check_eq("ctrl_upper_ignored", ctrl_data_out, 8'h00);
    wr_div(8'hA5);
    check_eq("div_exact", div_data_out, 8'hA5);

    // div=3, sysclk source: pulse every 4 cycles, first 4 after ctrl write
    wr_div(8'd3);
    wr_ctrl(8'h01);
    clear_log();
    repeat (12) step();
    check_eq("d3_count", tick_steps.size(), 3);
    check_eq("d3_first", tick_at(0), 4);
    check_eq("d3_third", tick_at(2), 12);

    // div=0 and div=1 both alternate
    wr_div(8'd0);
    clear_log();
    repeat (6) step();
    check_eq("d0_pattern", tick_hist[5:0], 6'b010101);
    wr_div(8'd1);
    clear_log();
    repeat (6) step();
    check_eq("d1_pattern", tick_hist[5:0], 6'b010101);

    // div reload at count==5 during a qualified event drops the tick
    wr_div(8'd5);
    repeat (5) step();
    wr_div(8'd5);
    check_eq("reload_drop", tick, 0);
    clear_log();
    repeat (8) step();
    check_eq("reload_count", tick_steps.size(), 1);
    check_eq("reload_first", tick_at(0), 6);

    // both edges, div=1, 4 toggles spaced 5 cycles
    wr_ctrl(8'h07);
    wr_div(8'd1);
    clear_log();
    for (int i = 0; i < 25; i++) begin
      if ((i % 5) == 0 && i < 20) ext_event = ~ext_event;
      step();
    end
    check_eq("both_count", tick_steps.size(), 2);
    check_eq("both_first", tick_at(0), 9);
    check_eq("both_second", tick_at(1), 19);

    // falling edges only, div=2, 3 rising + 3 falling edges
    wr_ctrl(8'h05);
    wr_div(8'd2);
    clear_log();
    for (int i = 0; i < 28; i++) begin
      if ((i % 4) == 0 && i < 24) ext_event = ~ext_event;
      step();
    end
    check_eq("fall_count", tick_steps.size(), 1);
    check_eq("fall_pos", tick_at(0), 24);

    // all-ones divisor counts the full range
    wr_ctrl(8'h01);
    wr_div(8'hFF);
    clear_log();
    repeat (260) step();
    check_eq("ff_count", tick_steps.size(), 1);
    check_eq("ff_pos", tick_at(0), 256);

    // simultaneous writes load both registers
    data_in = 8'h01; ctrl_load = 1; div_load = 1;
    step();
    ctrl_load = 0; div_load = 0;
    check_eq("dual_ctrl", ctrl_data_out, 8'h01);
    check_eq("dual_div", div_data_out, 8'h01);

    // reset mid-period at count==2
    wr_div(8'd5);
    repeat (2) step();
    #2;
    sysreset = 1'b1;
    #1;
    model_reset();
    check_eq("midrst_tick", tick, 0);
    check_eq("midrst_ctrl", ctrl_data_out[2:0], 0);
    check_eq("midrst_div", div_data_out, 0);
    @(posedge sysclk); #1;
    sysreset = 1'b0;
    clear_log();
    repeat (10) step();
    check_eq("midrst_quiet", tick_steps.size(), 0);
    wr_ctrl(8'h01);
    clear_log();
    repeat (4) step();
    check_eq("reen_count", tick_steps.size(), 2);
    check_eq("reen_first", tick_at(0), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
